// File: rtl/instruction_fetch.sv
// IF stage: program counter, word-addressed instruction memory with a loader
// write port, and the IF/ID register. Define FETCH_FLUSH_ON_JUMP_EN to squash the word after a jump.
module instruction_fetch #(
  parameter int NB_DATA     = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int NB_MEM_ADDR = 8
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_run,
  input  logic                   i_inst_we,
  input  logic [NB_MEM_ADDR-1:0] i_inst_wr_addr,
  input  logic [NB_DATA-1:0]     i_inst_wr_data,
  input  logic                   i_jump,
  input  logic [NB_DATA-1:0]     i_addr2jump,
  input  logic                   i_stall,
  input  logic                   i_halt,
  output logic [NB_DATA-1:0]     o_instruction,
  output logic [NB_DATA-1:0]     o_pcounter4,
  output logic [NB_DATA-1:0]     o_pc,
  output logic                   o_valid,
  output logic                   o_end
);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_t;

  localparam logic [NB_DATA-1:0] HALT_WORD = '1;

  state_t                 state_q, state_d;
  logic [NB_DATA-1:0]     pc_q, pc_d;
  logic [NB_DATA-1:0]     instr_q, instr_d;
  logic [NB_DATA-1:0]     pc4_q, pc4_d;
  logic                   valid_q, valid_d;
  logic                   end_q, end_d;

  logic [NB_DATA-1:0]     mem [MEM_DEPTH];
  logic [NB_MEM_ADDR-1:0] fetch_idx;
  logic [NB_DATA-1:0]     fetch_word;
  logic [NB_DATA-1:0]     pc_plus4;
  logic                   unused_pc_bits;

  // Byte PC to word index; low two bits and bits above the memory range are ignored.
  assign fetch_idx      = pc_q[NB_MEM_ADDR+1:2];
  assign fetch_word     = mem[fetch_idx];
  assign pc_plus4       = pc_q + NB_DATA'(4);
  assign unused_pc_bits = ^{pc_q[1:0], pc_q[NB_DATA-1:NB_MEM_ADDR+2]};

  always_ff @(posedge clk) begin
    if (!i_rst && state_q == ST_LOAD && i_inst_we) begin
      mem[i_inst_wr_addr] <= i_inst_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_LOAD;
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    end_d   = end_q;
    case (state_q)
      ST_LOAD: begin
        if (i_run) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Halt outranks stall; a stalled jump is dropped since decode re-asserts it.
        if (!i_halt && !i_stall) begin
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          if (fetch_word == HALT_WORD) begin
            instr_d = fetch_word;
            end_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
`ifdef FETCH_FLUSH_ON_JUMP_EN
            instr_d = i_jump ? '0 : fetch_word;
`else
            instr_d = fetch_word;
`endif
            pc_d = i_jump ? i_addr2jump : pc_plus4;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_instruction = instr_q;
  assign o_pcounter4   = pc4_q;
  assign o_pc          = pc_q;
  assign o_valid       = valid_q;
  assign o_end         = end_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for load/run/halt-word,
// then hand sequences for jump, stall, halt, write-in-RUN and reset-mid-run.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        i_rst, i_run, i_inst_we, i_jump, i_stall, i_halt;
  logic [7:0]  i_inst_wr_addr;
  logic [31:0] i_inst_wr_data, i_addr2jump;
  logic [31:0] o_instruction, o_pcounter4, o_pc;
  logic        o_valid, o_end;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.NB_DATA(32), .MEM_DEPTH(256), .NB_MEM_ADDR(8)) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_run          (i_run),
    .i_inst_we      (i_inst_we),
    .i_inst_wr_addr (i_inst_wr_addr),
    .i_inst_wr_data (i_inst_wr_data),
    .i_jump         (i_jump),
    .i_addr2jump    (i_addr2jump),
    .i_stall        (i_stall),
    .i_halt         (i_halt),
    .o_instruction  (o_instruction),
    .o_pcounter4    (o_pcounter4),
    .o_pc           (o_pc),
    .o_valid        (o_valid),
    .o_end          (o_end)
  );

  typedef struct {
    logic        rst, run, we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        jump;
    logic [31:0] a2j;
    logic        stall, halt;
    logic [31:0] e_instr, e_pc4, e_pc;
    logic        e_valid, e_end;
  } vec_t;

  localparam logic [31:0] HW  = 32'hFFFF_FFFF;
  localparam logic [31:0] A0  = 32'h1000_00A0;
  localparam logic [31:0] A1  = 32'h1000_00A1;
  localparam logic [31:0] A2  = 32'h1000_00A2;
  localparam logic [31:0] B16 = 32'h2000_0B16;
`ifdef FETCH_FLUSH_ON_JUMP_EN
  localparam logic [31:0] SLOT = 32'h0;
`else
  localparam logic [31:0] SLOT = A2;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs 1ns after the edge.
  task automatic apply(input vec_t v, input string tag);
    i_rst = v.rst; i_run = v.run; i_inst_we = v.we;
    i_inst_wr_addr = v.waddr; i_inst_wr_data = v.wdata;
    i_jump = v.jump; i_addr2jump = v.a2j; i_stall = v.stall; i_halt = v.halt;
    @(posedge clk);
    #1;
    chk({tag, ".instr"}, o_instruction, v.e_instr);
    chk({tag, ".pc4"},   o_pcounter4,   v.e_pc4);
    chk({tag, ".pc"},    o_pc,          v.e_pc);
    chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v.e_valid});
    chk({tag, ".end"},   {31'd0, o_end},   {31'd0, v.e_end});
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    i_rst = 1'b1; i_run = 1'b0; i_inst_we = 1'b0; i_inst_wr_addr = '0;
    i_inst_wr_data = '0; i_jump = 1'b0; i_addr2jump = '0; i_stall = 1'b0; i_halt = 1'b0;

    // rst run we waddr wdata jump a2j stall halt | instr pc4 pc valid end
    tbl[0]  = '{1, 0, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, 32'h0,        32'd0,  32'd0,  0, 0};
    tbl[1]  = '{0, 0, 1, 8'd0, 32'h2001_0005,  0, 32'h0, 0, 0, 32'h0,        32'd0,  32'd0,  0, 0};
    tbl[2]  = '{0, 0, 1, 8'd1, 32'h2002_0007,  0, 32'h0, 0, 0, 32'h0,        32'd0,  32'd0,  0, 0};
    tbl[3]  = '{0, 0, 1, 8'd2, 32'h0022_1820,  0, 32'h0, 0, 0, 32'h0,        32'd0,  32'd0,  0, 0};
    tbl[4]  = '{0, 1, 1, 8'd3, HW,             0, 32'h0, 0, 0, 32'h0,        32'd0,  32'd0,  0, 0};
    tbl[5]  = '{0, 0, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, 32'h2001_0005, 32'd4,  32'd4,  1, 0};
    tbl[6]  = '{0, 0, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, 32'h2002_0007, 32'd8,  32'd8,  1, 0};
    tbl[7]  = '{0, 0, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, 32'h0022_1820, 32'd12, 32'd12, 1, 0};
    tbl[8]  = '{0, 0, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, HW,           32'd16, 32'd12, 1, 1};
    tbl[9]  = '{0, 0, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, HW,           32'd16, 32'd12, 1, 1};
    tbl[10] = '{0, 0, 1, 8'd5, 32'h55,         1, 32'h40, 0, 0, HW,          32'd16, 32'd12, 1, 1};
    tbl[11] = '{0, 1, 0, 8'd0, 32'h0,          0, 32'h0, 0, 0, HW,           32'd16, 32'd12, 1, 1};

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("prog%0d", i));

    // Jump from PC=8 to 0x40; word at 8 is the delay slot.
    v = '{1, 0, 0, 8'd0,  32'h0, 0, 32'h0, 0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "j_rst");
    v = '{0, 0, 1, 8'd0,  A0,    0, 32'h0, 0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "j_ld0");
    v = '{0, 0, 1, 8'd1,  A1,    0, 32'h0, 0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "j_ld1");
    v = '{0, 0, 1, 8'd2,  A2,    0, 32'h0, 0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "j_ld2");
    v = '{0, 0, 1, 8'd16, B16,   0, 32'h0, 0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "j_ld16");
    v = '{0, 1, 1, 8'd17, HW,    0, 32'h0, 0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "j_ld17");
    v = '{0, 0, 0, 8'd0,  32'h0, 0, 32'h0,  0, 0, A0,   32'd4,    32'd4,    1, 0}; apply(v, "j_f0");
    v = '{0, 0, 0, 8'd0,  32'h0, 0, 32'h0,  0, 0, A1,   32'd8,    32'd8,    1, 0}; apply(v, "j_f1");
    v = '{0, 0, 0, 8'd0,  32'h0, 1, 32'h40, 0, 0, SLOT, 32'd12,   32'h40,   1, 0}; apply(v, "j_jump");
    v = '{0, 0, 0, 8'd0,  32'h0, 0, 32'h0,  0, 0, B16,  32'h44,   32'h44,   1, 0}; apply(v, "j_tgt");
    v = '{0, 0, 0, 8'd0,  32'h0, 0, 32'h0,  0, 0, HW,   32'h48,   32'h44,   1, 1}; apply(v, "j_end");

    // Stall with jump asserted, halt with jump asserted, then a misaligned jump.
    v = '{1, 0, 0, 8'd0, 32'h0, 0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "s_rst");
    v = '{0, 1, 0, 8'd0, 32'h0, 0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0, 0, 0}; apply(v, "s_run");
    v = '{0, 0, 0, 8'd0, 32'h0, 0, 32'h0,  0, 0, A0,    32'd4, 32'd4, 1, 0}; apply(v, "s_f0");
    v = '{0, 0, 0, 8'd0, 32'h0, 1, 32'h40, 1, 0, A0,    32'd4, 32'd4, 1, 0}; apply(v, "s_stall1");
    v = '{0, 0, 0, 8'd0, 32'h0, 1, 32'h40, 1, 0, A0,    32'd4, 32'd4, 1, 0}; apply(v, "s_stall2");
    v = '{0, 0, 0, 8'd0, 32'h0, 0, 32'h0,  0, 0, A1,    32'd8, 32'd8, 1, 0}; apply(v, "s_resume");
    v = '{0, 0, 0, 8'd0, 32'h0, 1, 32'h40, 0, 1, A1,    32'd8, 32'd8, 1, 0}; apply(v, "h_halt1");
    v = '{0, 0, 0, 8'd0, 32'h0, 1, 32'h40, 1, 1, A1,    32'd8, 32'd8, 1, 0}; apply(v, "h_halt2");
    v = '{0, 0, 0, 8'd0, 32'h0, 1, 32'h43, 0, 0, SLOT,  32'd12, 32'h43, 1, 0}; apply(v, "m_jump");
    v = '{0, 0, 0, 8'd0, 32'h0, 0, 32'h0,  0, 0, B16,   32'h47, 32'h47, 1, 0}; apply(v, "m_tgt");
    v = '{0, 0, 0, 8'd0, 32'h0, 0, 32'h0,  0, 0, HW,    32'h4B, 32'h47, 1, 1}; apply(v, "m_end");

    // Write attempted in RUN while jumping to 0x20, reset there, rerun from retained memory.
    v = '{1, 0, 0, 8'd0, 32'h0,        0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0,  0, 0}; apply(v, "r_rst");
    v = '{0, 1, 0, 8'd0, 32'h0,        0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0,  0, 0}; apply(v, "r_run");
    v = '{0, 0, 1, 8'd0, 32'hDEADBEEF, 1, 32'h20, 0, 0, SLOT == A2 ? A0 : 32'h0, 32'd4, 32'h20, 1, 0};
    apply(v, "r_wr_jump");
    v = '{1, 1, 1, 8'd1, 32'hDEADBEEF, 0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0,  0, 0}; apply(v, "r_midrst");
    v = '{0, 0, 0, 8'd0, 32'h0,        0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0,  0, 0}; apply(v, "r_load");
    v = '{0, 1, 0, 8'd0, 32'h0,        0, 32'h0,  0, 0, 32'h0, 32'd0, 32'd0,  0, 0}; apply(v, "r_run2");
    v = '{0, 0, 0, 8'd0, 32'h0,        0, 32'h0,  0, 0, A0,    32'd4, 32'd4,  1, 0}; apply(v, "r_f0");
    v = '{0, 0, 0, 8'd0, 32'h0,        0, 32'h0,  0, 0, A1,    32'd8, 32'd8,  1, 0}; apply(v, "r_f1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
